// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Multicycle control FSM sitting directly upstream of the ALU. It decodes the
//   IR opcode/funct fields and sequences each instruction through
//   IF -> ID -> EXE -> MEM -> WB. It drives the ALU operand/operation selects
//   and the datapath enables. It consumes the ALU flags for branch resolution
//   and for suppressing the addi writeback on overflow.
//
// Ports
//   clk        in   1  clock, all state updates on posedge
//   rst        in   1  synchronous, active-high reset
//   opcode     in   6  IR[31:26]
//   funct      in   6  IR[5:0], only meaningful for R-type (opcode 000000)
//   zero       in   1  ALU zero flag (beq)
//   overflow   in   1  ALU overflow flag (addi)
//   condition  in   1  ALU greater-than-zero flag (bgtz)
//   ALU_Src    out  1  0: rt operand, 1: extended immediate
//   ALU_op     out  3  ALU operation code
//   ExtSel     out  2  00 zero-ext, 01 sign-ext, 10 imm<<16
//   PCWre      out  1  PC write enable
//   PC_Src     out  2  00 PC+4, 01 branch target, 10 jump target
//   IRWre      out  1  IR load enable
//   RegWre     out  1  register-file write enable
//   RegDst     out  1  0: write rt, 1: write rd
//   WrRegSrc   out  1  0: ALU result, 1: memory data
//   MemRd      out  1  data-memory read strobe
//   MemWr      out  1  data-memory write strobe
//   state      out  3  current FSM state (debug)
//   halted     out  1  high while in HALT
// -----------------------------------------------------------------------------
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       condition,
  output logic       ALU_Src,
  output logic [2:0] ALU_op,
  output logic [1:0] ExtSel,
  output logic       PCWre,
  output logic [1:0] PC_Src,
  output logic       IRWre,
  output logic       RegWre,
  output logic       RegDst,
  output logic       WrRegSrc,
  output logic       MemRd,
  output logic       MemWr,
  output logic [2:0] state,
  output logic       halted
);

  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_EXE  = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_WB   = 3'b100;
  localparam logic [2:0] S_HALT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  logic [2:0] next_state;
  logic       ov_q;

  // Decoded instruction class and ALU controls
  logic       is_valid;
  logic       is_r;
  logic       is_addi;
  logic       is_lw;
  logic       is_sw;
  logic       is_beq;
  logic       is_bgtz;
  logic       is_j;
  logic       is_halt;
  logic       dec_src;
  logic [2:0] dec_op;
  logic [1:0] dec_ext;

  always_comb begin
    is_valid = 1'b1;
    is_r     = 1'b0;
    is_addi  = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_beq   = 1'b0;
    is_bgtz  = 1'b0;
    is_j     = 1'b0;
    is_halt  = 1'b0;
    dec_src  = 1'b0;
    dec_op   = 3'b000;
    dec_ext  = 2'b00;
    case (opcode)
      OP_RTYPE: begin
        is_r = 1'b1;
        case (funct)
          FN_ADDU: dec_op = 3'b000;
          FN_SUBU: dec_op = 3'b001;
          FN_OR:   dec_op = 3'b010;
          FN_SLT:  dec_op = 3'b011;
          default: is_valid = 1'b0;
        endcase
      end
      OP_ADDIU: begin dec_src = 1'b1; dec_op = 3'b000; dec_ext = 2'b01; end
      OP_ADDI:  begin is_addi = 1'b1; dec_src = 1'b1; dec_op = 3'b100; dec_ext = 2'b01; end
      OP_ORI:   begin dec_src = 1'b1; dec_op = 3'b010; dec_ext = 2'b00; end
      OP_LUI:   begin dec_src = 1'b1; dec_op = 3'b101; dec_ext = 2'b10; end
      OP_LW:    begin is_lw = 1'b1; dec_src = 1'b1; dec_op = 3'b000; dec_ext = 2'b01; end
      OP_SW:    begin is_sw = 1'b1; dec_src = 1'b1; dec_op = 3'b000; dec_ext = 2'b01; end
      OP_BEQ:   begin is_beq = 1'b1; dec_op = 3'b001; end
      OP_BGTZ:  begin is_bgtz = 1'b1; dec_op = 3'b110; end
      OP_J:     is_j = 1'b1;
      OP_HALT:  is_halt = 1'b1;
      default:  is_valid = 1'b0;
    endcase
  end

  // State register and overflow latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IF;
      ov_q  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_IF)
        ov_q <= 1'b0;
      else if (state == S_EXE && is_addi)
        ov_q <= overflow;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = S_IF;
    case (state)
      S_IF: next_state = S_ID;
      S_ID: begin
        if (!is_valid || is_j) next_state = S_IF;   // undefined behaves as a nop
        else if (is_halt)      next_state = S_HALT;
        else                   next_state = S_EXE;
      end
      S_EXE: begin
        if (is_beq || is_bgtz)  next_state = S_IF;
        else if (is_lw || is_sw) next_state = S_MEM;
        else                     next_state = S_WB;
      end
      S_MEM:   next_state = is_lw ? S_WB : S_IF;
      S_WB:    next_state = S_IF;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IF;
    endcase
  end

  // Output decode; write-type enables are masked while rst is asserted
  always_comb begin
    ALU_Src  = 1'b0;
    ALU_op   = 3'b000;
    ExtSel   = 2'b00;
    PC_Src   = 2'b00;
    RegDst   = 1'b0;
    WrRegSrc = 1'b0;
    halted   = (state == S_HALT);
    IRWre    = !rst && (state == S_IF);
    // The cycle that hands control back to IF is the instruction's last one
    PCWre    = !rst && (state != S_HALT) && (next_state == S_IF);
    RegWre   = !rst && (state == S_WB) && !(is_addi && ov_q);
    MemRd    = !rst && (state == S_MEM) && is_lw;
    MemWr    = !rst && (state == S_MEM) && is_sw;

    if (state == S_EXE || state == S_MEM || state == S_WB) begin
      ALU_Src = dec_src;
      ALU_op  = dec_op;
      ExtSel  = dec_ext;
    end

    if (state == S_ID && is_j)
      PC_Src = 2'b10;
    else if (state == S_EXE && ((is_beq && zero) || (is_bgtz && condition)))
      PC_Src = 2'b01;

    if (state == S_WB) begin
      RegDst   = is_r;
      WrRegSrc = is_lw;
    end
  end

endmodule
